// File: rtl/delta_compressor_ms.sv
// Purpose: N-lane delta compressor packing per-lane deltas into slots of a word, with raw base/keyframe vectors.
// Latency: one cycle from an accepted input to the registered output word.
// Backpressure: none; every accepted input yields exactly one output word the following cycle.
module delta_compressor_ms #(
    parameter int   N             = 8,
    parameter int   DATA_WIDTH    = 32,
    parameter int   MAX_LOG_SLOTS = 2,
    parameter logic COMPRESSED    = 1'b0,
    parameter int   KEYFRAME_INT  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tracing,
    input  logic                    valid_in,
    input  logic [1:0]              log_slots,
    input  logic [N*DATA_WIDTH-1:0] vector_in,
    output logic                    valid_out,
    output logic [N*DATA_WIDTH-1:0] vector_out,
    output logic                    v_out_comp,
    output logic                    inc_tb_ptr
);

    localparam int DW = DATA_WIDTH;
    // One precision variant is built per legal log2(slots) value.
    localparam int NL = MAX_LOG_SLOTS + 1;
    localparam logic [1:0] MAX_LS = 2'(MAX_LOG_SLOTS);
    localparam int KW = (KEYFRAME_INT > 0) ? $clog2(KEYFRAME_INT + 1) : 1;
    localparam logic [KW-1:0] KF_LIMIT = KW'(KEYFRAME_INT);
    // NODATA for a single full-width slot: the state after reset (ls = 0).
    localparam logic [DW-1:0] INV_FULL = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BASE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t          state_q;
    logic [1:0]      ls_q;
    logic [2:0]      ptr_q;
    logic [KW-1:0]   kf_q;
    logic [N*DW-1:0] last_q;
    logic [DW-1:0]   comp_q [N];

    logic            valid_q;
    logic [N*DW-1:0] vec_out_q;
    logic            comp_flag_q;
    logic            inc_q;

    assign valid_out  = valid_q;
    assign vector_out = vec_out_q;
    assign v_out_comp = comp_flag_q;
    assign inc_tb_ptr = inc_q;

    // Requested precision, clamped to the largest variant that was built.
    logic [1:0] ls_new;
    assign ls_new = (log_slots > MAX_LS) ? MAX_LS : log_slots;

    // Per-lane delta, prev - cur, modulo 2^DW.
    logic [DW-1:0] delta [N];
    for (genvar i = 0; i < N; i++) begin : g_delta
        assign delta[i] = last_q[i*DW +: DW] - vector_in[i*DW +: DW];
    end

    // Candidate words, overflow flags and NODATA patterns for every precision.
    logic [DW-1:0] cand_l   [NL][N];
    logic          ovf_l    [NL][N];
    logic [DW-1:0] nodata_l [NL];

    for (genvar l = 0; l < NL; l++) begin : g_prec
        localparam int P = DW >> l;
        localparam int S = 1 << l;
        localparam logic [P-1:0] INV = {1'b1, {(P-1){1'b0}}};

        assign nodata_l[l] = {S{INV}};

        for (genvar i = 0; i < N; i++) begin : g_lane
            logic [DW-1:0] word;
            logic          ovf;

            // Delta must sign-extend from P bits, and the most negative code is reserved as INV.
            assign ovf = (delta[i][DW-1:P-1] != {(DW-P+1){delta[i][DW-1]}}) ||
                         (delta[i][P-1:0] == INV);

            // Slot 0 sits in the MSBs; earlier slots keep their deltas, later slots read INV.
            for (genvar k = 0; k < S; k++) begin : g_slot
                assign word[DW-1-k*P -: P] = (ptr_q > 3'(k))  ? comp_q[i][DW-1-k*P -: P] :
                                             (ptr_q == 3'(k)) ? delta[i][P-1:0] :
                                                                INV;
            end

            assign cand_l[l][i] = word;
            assign ovf_l[l][i]  = ovf;
        end
    end

    // Pick the variant matching the latched precision (and NODATA for the incoming one).
    logic [DW-1:0]   cand_sel [N];
    logic [N*DW-1:0] cand_flat;
    logic            ovf_any;
    logic [DW-1:0]   nodata_cur;
    logic [DW-1:0]   nodata_new;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            cand_sel[i] = '0;
        end
        ovf_any    = 1'b0;
        nodata_cur = INV_FULL;
        nodata_new = INV_FULL;
        for (int l = 0; l < NL; l++) begin
            if (ls_q == 2'(l)) begin
                nodata_cur = nodata_l[l];
                for (int i = 0; i < N; i++) begin
                    cand_sel[i] = cand_l[l][i];
                    ovf_any     = ovf_any | ovf_l[l][i];
                end
            end
            if (ls_new == 2'(l)) begin
                nodata_new = nodata_l[l];
            end
        end
    end

    // Flatten the selected lanes into the output vector layout.
    always_comb begin
        cand_flat = '0;
        for (int i = 0; i < N; i++) begin
            cand_flat[i*DW +: DW] = cand_sel[i];
        end
    end

    // Slot bookkeeping: last slot index of the word and forced-keyframe condition.
    logic [2:0] last_slot;
    logic       wrap;
    logic       kf_hit;
    logic       take_raw;

    assign last_slot = 3'((4'd1 << ls_q) - 4'd1);
    assign wrap      = (ptr_q == last_slot);
    assign kf_hit    = (KEYFRAME_INT != 0) && (kf_q == KF_LIMIT);
    assign take_raw  = ovf_any || kf_hit;

    // Control FSM with registered outputs; tracing low overrides everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ls_q        <= '0;
            ptr_q       <= '0;
            kf_q        <= '0;
            last_q      <= '0;
            for (int i = 0; i < N; i++) begin
                comp_q[i] <= INV_FULL;
            end
            valid_q     <= 1'b0;
            vec_out_q   <= '0;
            comp_flag_q <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (!tracing) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_BASE;
                    end
                    ST_BASE: begin
                        if (valid_in) begin
                            ls_q        <= ls_new;
                            last_q      <= vector_in;
                            vec_out_q   <= vector_in;
                            valid_q     <= 1'b1;
                            comp_flag_q <= ~COMPRESSED;
                            inc_q       <= 1'b1;
                            ptr_q       <= '0;
                            kf_q        <= '0;
                            for (int i = 0; i < N; i++) begin
                                comp_q[i] <= nodata_new;
                            end
                            state_q     <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (valid_in) begin
                            last_q  <= vector_in;
                            valid_q <= 1'b1;
                            if (take_raw) begin
                                vec_out_q   <= vector_in;
                                comp_flag_q <= ~COMPRESSED;
                                inc_q       <= 1'b1;
                                ptr_q       <= '0;
                                kf_q        <= '0;
                                for (int i = 0; i < N; i++) begin
                                    comp_q[i] <= nodata_cur;
                                end
                            end else begin
                                vec_out_q   <= cand_flat;
                                comp_flag_q <= COMPRESSED;
                                inc_q       <= (ptr_q == 3'd0);
                                ptr_q       <= wrap ? 3'd0 : ptr_q + 3'd1;
                                kf_q        <= kf_q + KW'(1);
                                for (int i = 0; i < N; i++) begin
                                    comp_q[i] <= wrap ? nodata_cur : cand_sel[i];
                                end
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_delta_compressor_ms.sv
// Purpose: directed scoreboard bench for delta_compressor_ms (default DUT plus a KEYFRAME_INT=4 DUT).
// Latency: expects each accepted input to appear on the outputs exactly one cycle later.
// Backpressure: none; monitors pop one expectation per valid_out pulse.
module tb_delta_compressor_ms;

    localparam logic COMP = 1'b0;

    logic         clk;
    logic         rst;
    logic         tracing_a;
    logic         tracing_k;
    logic         valid_in;
    logic [1:0]   log_slots;
    logic [255:0] vector_in;

    logic         valid_out_a;
    logic [255:0] vector_out_a;
    logic         v_out_comp_a;
    logic         inc_tb_ptr_a;

    logic         valid_out_k;
    logic [255:0] vector_out_k;
    logic         v_out_comp_k;
    logic         inc_tb_ptr_k;

    delta_compressor_ms #(
        .N(8), .DATA_WIDTH(32), .MAX_LOG_SLOTS(2), .COMPRESSED(COMP), .KEYFRAME_INT(16)
    ) dut_a (
        .clk(clk), .rst(rst), .tracing(tracing_a), .valid_in(valid_in),
        .log_slots(log_slots), .vector_in(vector_in),
        .valid_out(valid_out_a), .vector_out(vector_out_a),
        .v_out_comp(v_out_comp_a), .inc_tb_ptr(inc_tb_ptr_a)
    );

    delta_compressor_ms #(
        .N(8), .DATA_WIDTH(32), .MAX_LOG_SLOTS(2), .COMPRESSED(COMP), .KEYFRAME_INT(4)
    ) dut_k (
        .clk(clk), .rst(rst), .tracing(tracing_k), .valid_in(valid_in),
        .log_slots(log_slots), .vector_in(vector_in),
        .valid_out(valid_out_k), .vector_out(vector_out_k),
        .v_out_comp(v_out_comp_k), .inc_tb_ptr(inc_tb_ptr_k)
    );

    typedef struct {
        logic [255:0] vec;
        logic         comp;
        logic         inc;
        int           cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qk[$];
    exp_t ea;
    exp_t ek;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_vec(input logic [31:0] l0, input logic [31:0] oth);
        logic [255:0] v;
        v[31:0] = l0;
        for (int i = 1; i < 8; i++) v[i*32 +: 32] = oth + 32'(i);
        return v;
    endfunction

    function automatic logic [255:0] mk_comp(input logic [31:0] w0, input logic [31:0] wo);
        logic [255:0] v;
        v[31:0] = w0;
        for (int i = 1; i < 8; i++) v[i*32 +: 32] = wo;
        return v;
    endfunction

    // Scoreboard monitors: compare every output pulse with the oldest expectation.
    always @(negedge clk) begin
        if (valid_out_a === 1'b1) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_stray: valid_out=1 with no expected word, vector %h", vector_out_a);
            end else begin
                ea = qa.pop_front();
                check("a_cycle", 256'(cyc), 256'(ea.cyc));
                check("a_vector", vector_out_a, ea.vec);
                check1("a_comp", v_out_comp_a, ea.comp);
                check1("a_inc", inc_tb_ptr_a, ea.inc);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_out_k === 1'b1) begin
            if (qk.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL k_stray: valid_out=1 with no expected word, vector %h", vector_out_k);
            end else begin
                ek = qk.pop_front();
                check("k_cycle", 256'(cyc), 256'(ek.cyc));
                check("k_vector", vector_out_k, ek.vec);
                check1("k_comp", v_out_comp_k, ek.comp);
                check1("k_inc", inc_tb_ptr_k, ek.inc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one accepted input and queue its expected output word.
    task automatic drive(input bit sel, input logic [31:0] l0, input logic [31:0] oth,
                         input bit is_raw, input logic [31:0] w0, input logic [31:0] wo,
                         input logic inc);
        exp_t e;
        vector_in = mk_vec(l0, oth);
        valid_in  = 1'b1;
        e.vec  = is_raw ? mk_vec(l0, oth) : mk_comp(w0, wo);
        e.comp = is_raw ? ~COMP : COMP;
        e.inc  = inc;
        e.cyc  = cyc + 1;
        if (sel) qk.push_back(e);
        else     qa.push_back(e);
        step();
        valid_in = 1'b0;
    endtask

    // Drop tracing for a cycle, then raise it so the DUT sits in BASE.
    task automatic restart(input logic [1:0] ls, input bit sel);
        valid_in  = 1'b0;
        log_slots = ls;
        if (sel) tracing_k = 1'b0;
        else     tracing_a = 1'b0;
        step();
        if (sel) tracing_k = 1'b1;
        else     tracing_a = 1'b1;
        step();
    endtask

    localparam logic [31:0] OTH = 32'h1000;

    logic [31:0] kw [4];

    initial begin
        rst = 1'b1; tracing_a = 1'b0; tracing_k = 1'b0; valid_in = 1'b0;
        log_slots = 2'd0; vector_in = '0;
        kw[0] = 32'h00808080; kw[1] = 32'h00008080; kw[2] = 32'h00000080; kw[3] = 32'h00000000;

        step();
        check1("reset_valid", valid_out_a, 1'b0);
        check("reset_vector", vector_out_a, 256'd0);
        check1("reset_comp", v_out_comp_a, 1'b0);
        check1("reset_inc", inc_tb_ptr_a, 1'b0);
        check1("reset_valid_k", valid_out_k, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Basic compression, 4 slots of 8 bits.
        restart(2'd2, 0);
        drive(0, 100, OTH, 1, 0, 0, 1'b1);
        drive(0,  99, OTH, 0, 32'h01808080, 32'h00808080, 1'b1);
        drive(0,  97, OTH, 0, 32'h01028080, 32'h00008080, 1'b0);
        drive(0, 100, OTH, 0, 32'h0102FD80, 32'h00000080, 1'b0);
        drive(0, 100, OTH, 0, 32'h0102FD00, 32'h00000000, 1'b0);
        drive(0, 100, OTH, 0, 32'h00808080, 32'h00808080, 1'b1);

        // Overflow boundaries: +127 fits, -128 reserved, -129 and +128 overflow, -127 fits.
        restart(2'd2, 0);
        drive(0, 0,            OTH, 1, 0, 0, 1'b1);
        drive(0, 32'hFFFFFF81, OTH, 0, 32'h7F808080, 32'h00808080, 1'b1);
        drive(0, 1,            OTH, 1, 0, 0, 1'b1);
        drive(0, 130,          OTH, 1, 0, 0, 1'b1);
        drive(0, 130,          OTH, 0, 32'h00808080, 32'h00808080, 1'b1);
        drive(0, 2,            OTH, 1, 0, 0, 1'b1);
        drive(0, 129,          OTH, 0, 32'h81808080, 32'h00808080, 1'b1);

        // Precision mode: 2 slots of 16 bits; a mid-run log_slots change is ignored.
        restart(2'd1, 0);
        drive(0, 1000, OTH, 1, 0, 0, 1'b1);
        drive(0,  990, OTH, 0, 32'h000A8000, 32'h00008000, 1'b1);
        log_slots = 2'd3;
        drive(0,  985, OTH, 0, 32'h000A0005, 32'h00000000, 1'b0);
        drive(0,  984, OTH, 0, 32'h00018000, 32'h00008000, 1'b1);
        // Idle cycles leave state untouched.
        step();
        step();
        drive(0,  984, OTH, 0, 32'h00010000, 32'h00000000, 1'b0);
        drive(0,  983, OTH, 0, 32'h00018000, 32'h00008000, 1'b1);

        // Tracing drop mid-word: inputs offered while idle are not accepted; log_slots 3 clamps to 2.
        vector_in = mk_vec(500, OTH);
        valid_in  = 1'b1;
        tracing_a = 1'b0;
        step();
        tracing_a = 1'b1;
        step();
        drive(0, 500, OTH, 1, 0, 0, 1'b1);
        drive(0, 501, OTH, 0, 32'hFF808080, 32'h00808080, 1'b1);
        drive(0, 501, OTH, 0, 32'hFF008080, 32'h00008080, 1'b0);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check1("async_valid", valid_out_a, 1'b0);
        check("async_vector", vector_out_a, 256'd0);
        check1("async_comp", v_out_comp_a, 1'b0);
        check1("async_inc", inc_tb_ptr_a, 1'b0);
        step();
        rst = 1'b0;
        step();
        drive(0, 501, OTH, 1, 0, 0, 1'b1);
        drive(0, 501, OTH, 0, 32'h00808080, 32'h00808080, 1'b1);

        // Forced keyframes every 4 compressed inputs.
        tracing_a = 1'b0;
        restart(2'd2, 1);
        drive(1, 5, 5, 1, 0, 0, 1'b1);
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 4; j++) begin
                drive(1, 5, 5, 0, kw[j], kw[j], (j == 0));
            end
            if (r == 0) drive(1, 5, 5, 1, 0, 0, 1'b1);
        end

        tracing_k = 1'b0;
        repeat (4) step();
        check("qa_drained", 256'(qa.size()), 256'd0);
        check("qk_drained", 256'(qk.size()), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/delta_compressor_ms.md
Name: delta_compressor_ms

Overview:
- Next-generation N-lane delta compressor sitting between the vector datapath and the trace buffer.
- Adds the following over the current compressor:
  - runtime-selectable delta precision (slots per word);
  - raw emission of every base vector;
  - periodic forced keyframes;
  - asynchronous reset.
- Output is one registered word-vector per accepted input, plus trace-buffer pointer-increment control.

Parameters:
- N, 8, number of lanes.
- DATA_WIDTH, 32, lane width in bits. Must be divisible by 2^MAX_LOG_SLOTS, with DATA_WIDTH>>MAX_LOG_SLOTS ≥ 2.
- MAX_LOG_SLOTS, 2, maximum log2(delta slots per word); legal values 0..3.
- COMPRESSED, 0, value driven on v_out_comp for compressed words; raw words carry ~COMPRESSED.
- KEYFRAME_INT, 16, maximum consecutive compressed inputs before a forced raw vector. 0 disables forced keyframes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- tracing  in  1  compression enable; low returns block to IDLE.
- valid_in  in  1  vector_in valid this cycle.
- log_slots  in  2  requested log2(slots per word); clamped to MAX_LOG_SLOTS.
- vector_in  in  N x DATA_WIDTH  input lanes.
- valid_out  out  1  one-cycle pulse: vector_out valid.
- vector_out  out  N x DATA_WIDTH  compressed word or raw vector.
- v_out_comp  out  1  COMPRESSED for compressed words, ~COMPRESSED for raw.
- inc_tb_ptr  out  1  trace buffer must advance before writing this word; else overwrite current entry.

Behaviour:
- Reset (async, rst=1): all outputs 0, state=IDLE, ptr=0, kf_cnt=0, last_vector=0, comp_reg=NODATA.
- Derived values:
  - S = 1<<ls and P = DATA_WIDTH>>ls, where ls is the latched, clamped log_slots.
  - INV = P-bit value 1 followed by zeros.
  - NODATA = S copies of INV.
  - Legal delta range: −(2^(P−1)−1) .. +(2^(P−1)−1). −2^(P−1) is reserved and counts as overflow.
- Input acceptance: an input is accepted when valid_in=1 and tracing=1 in state BASE or RUN.
- Latency: all outputs register 1 cycle after acceptance. valid_out=0 in any cycle with no acceptance.
- States:
  - IDLE: entered on reset or whenever tracing=0 (tracing=0 has priority over everything). Transitions to BASE when tracing=1.
  - BASE: on acceptance:
    - latch ls from log_slots;
    - last_vector=vector_in;
    - emit raw vector_in with v_out_comp=~COMPRESSED, inc_tb_ptr=1;
    - ptr=0, kf_cnt=0, comp_reg=NODATA;
    - go to RUN.
  - RUN: on acceptance, delta[i] = last_vector[i] − vector_in[i], computed modulo 2^DATA_WIDTH and compared as signed.
    - Raw path, taken if any lane overflows OR (KEYFRAME_INT≠0 and kf_cnt==KEYFRAME_INT):
      - emit raw vector_in, v_out_comp=~COMPRESSED, inc_tb_ptr=1;
      - ptr=0, kf_cnt=0, comp_reg=NODATA.
    - Compressed path, otherwise:
      - Slot k occupies bits [DATA_WIDTH−1−k·P −: P].
      - comp_reg[i]: slots <ptr kept, slot ptr = delta[i][P−1:0], slots >ptr = INV.
      - Emit comp_reg with v_out_comp=COMPRESSED and inc_tb_ptr=(ptr==0).
      - ptr = (ptr==S−1) ? 0 : ptr+1; kf_cnt++.
      - When ptr wraps, comp_reg resets to NODATA for the next word.
    - In both paths, last_vector=vector_in.
- log_slots changes during BASE/RUN are ignored; they take effect only at the next BASE.
- With ls=0 (S=1, P=DATA_WIDTH), every compressed word has inc_tb_ptr=1.
- Decoder contract: cur = prev − delta, reconstructed forward from the latest raw word. INV marks unused slots.
- A tracing drop mid-word leaves the last written word in place; nothing is flushed.

Test Plan:
- Basic compression, DATA_WIDTH=32, log_slots=2, lane0 inputs 100, 99, 97, 100, 100, 100:
  - outputs 100 raw (inc=1);
  - 0x01808080 (inc=1, comp);
  - 0x01028080 (inc=0);
  - 0x0102FD80;
  - 0x0102FD00;
  - 0x00808080 (inc=1).
- Overflow, lane0 after base 0:
  - next input −127 (delta +127) → 0x7F808080 compressed;
  - input 1 (delta −128) → raw 1, inc=1, ptr reset;
  - input 130 (delta −129) → raw.
- Precision mode, log_slots=1: base 1000, then 990, 985, 984:
  - 0x000A8000 (inc=1);
  - 0x000A0005 (inc=0);
  - 0x00018000 (inc=1).
  - log_slots changed to 3 mid-run → no effect.
- Keyframe, KEYFRAME_INT=4, constant input 5: outputs are raw, 4 compressed, raw, 4 compressed, with the raw outputs at indices 0 and 5.
- Async reset: assert rst mid-word between clock edges → outputs 0 immediately. After release with tracing=1, the first accepted input emits raw.
- Tracing drop: tracing=0 for 1 cycle mid-word, then a new input → raw, inc=1, log_slots re-latched. valid_in=0 cycles produce valid_out=0 with state unchanged.
